// File: rtl/pingpong_pkg.sv
// ============================================================================
// Module   : pingpong_pkg
// Purpose  : Shared BCD constants, seven-segment table and BCD/binary helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pingpong_pkg;

   localparam int BCD_W = 4;

   // Active-low {g..a} patterns, digit 0 in bits [6:0]
   localparam logic [69:0] SEG7_LUT = {
      7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
      7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   localparam logic [6:0] SEG7_BLANK = 7'h7F;

   function automatic logic [31:0] bin_to_bcd(input int unsigned value);
      logic [31:0] result;
      int unsigned v;
      result = '0;
      v      = value;
      for (int i = 0; i < 8; i++) begin
         result[i*BCD_W +: BCD_W] = 4'(v % 10);
         v = v / 10;
      end
      return result;
   endfunction

   function automatic int unsigned bcd_to_bin(input logic [31:0] bcd);
      int unsigned result;
      result = 0;
      for (int i = 7; i >= 0; i--) begin
         result = result * 10 + 32'(bcd[i*BCD_W +: BCD_W]);
      end
      return result;
   endfunction

   function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
      logic [6:0] pattern;
      if (digit > 4'd9) begin
         pattern = SEG7_BLANK;
      end else begin
         pattern = SEG7_LUT[int'(digit)*7 +: 7];
      end
      return pattern;
   endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module   : btn_debounce
// Purpose  : Two-flop synchroniser, stability-window debouncer, press pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
   parameter int DB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic press_o
);

   localparam int               c_CW   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [c_CW-1:0] c_LAST = c_CW'(DB_CYCLES - 1);

   logic            sync1_q;
   logic            sync2_q;
   logic            level_q;
   logic            level_d;
   logic            press_q;
   logic            press_d;
   logic [c_CW-1:0] cnt_q;
   logic [c_CW-1:0] cnt_d;

   // Counter tracks consecutive samples that disagree with the debounced level
   always_comb begin
      level_d = level_q;
      press_d = 1'b0;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == c_LAST) begin
            level_d = sync2_q;
            press_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign press_o = press_q;

endmodule

`default_nettype wire

// File: rtl/bcd_pingpong_ctr.sv
// ============================================================================
// Module   : bcd_pingpong_ctr
// Purpose  : Prescaled BCD up/down counter bouncing between MIN and MAX.
//            Define SEG7_DECODE_EN to add the registered seven-segment port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_pingpong_ctr
   import pingpong_pkg::*;
#(
   parameter int DIGITS    = 4,
   parameter int MIN_COUNT = 0,
   parameter int MAX_COUNT = 9999,
   parameter int PRESCALE  = 1000000,
   parameter int DB_CYCLES = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      btn_run,
   input  logic                      btn_dir,
   input  logic                      clr,
   output logic [BCD_W*DIGITS-1:0]   bcd,
   output logic                      dir,
   output logic                      running,
   output logic                      turn
`ifdef SEG7_DECODE_EN
   ,
   output logic [7*DIGITS-1:0]       seg
`endif
);

   localparam int c_W  = BCD_W * DIGITS;
   localparam int c_PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(PRESCALE - 1);

   localparam int c_MAX_M1 = (MAX_COUNT > MIN_COUNT) ? MAX_COUNT - 1 : MAX_COUNT;
   localparam int c_MIN_P1 = (MAX_COUNT > MIN_COUNT) ? MIN_COUNT + 1 : MIN_COUNT;

   localparam logic [31:0] c_MIN_FULL    = bin_to_bcd(32'(MIN_COUNT));
   localparam logic [31:0] c_MAX_FULL    = bin_to_bcd(32'(MAX_COUNT));
   localparam logic [31:0] c_MAX_M1_FULL = bin_to_bcd(32'(c_MAX_M1));
   localparam logic [31:0] c_MIN_P1_FULL = bin_to_bcd(32'(c_MIN_P1));

   localparam logic [c_W-1:0] c_MIN_BCD    = c_MIN_FULL[c_W-1:0];
   localparam logic [c_W-1:0] c_MAX_BCD    = c_MAX_FULL[c_W-1:0];
   localparam logic [c_W-1:0] c_MAX_M1_BCD = c_MAX_M1_FULL[c_W-1:0];
   localparam logic [c_W-1:0] c_MIN_P1_BCD = c_MIN_P1_FULL[c_W-1:0];

   logic            w_run_press;
   logic            w_dir_press;
   logic            w_tick;
   logic            w_dir_eff;
   logic [c_W-1:0]  w_inc;
   logic [c_W-1:0]  w_dec;

   logic [c_W-1:0]  cnt_q;
   logic [c_W-1:0]  cnt_d;
   logic [c_PW-1:0] pre_q;
   logic [c_PW-1:0] pre_d;
   logic            dir_q;
   logic            dir_d;
   logic            running_q;
   logic            running_d;
   logic            turn_q;
   logic            turn_d;

   btn_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_db_run (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (btn_run),
      .press_o (w_run_press)
   );

   btn_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_db_dir (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (btn_dir),
      .press_o (w_dir_press)
   );

   assign w_tick    = running_q && (pre_q == c_PRE_LAST);
   assign w_dir_eff = dir_q ^ w_dir_press;

   // Ripple carry/borrow across all digits within one cycle
   always_comb begin
      logic carry;
      logic borrow;
      w_inc  = cnt_q;
      w_dec  = cnt_q;
      carry  = 1'b1;
      borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (cnt_q[i*BCD_W +: BCD_W] == 4'd9) begin
               w_inc[i*BCD_W +: BCD_W] = 4'd0;
            end else begin
               w_inc[i*BCD_W +: BCD_W] = cnt_q[i*BCD_W +: BCD_W] + 4'd1;
               carry = 1'b0;
            end
         end
         if (borrow) begin
            if (cnt_q[i*BCD_W +: BCD_W] == 4'd0) begin
               w_dec[i*BCD_W +: BCD_W] = 4'd9;
            end else begin
               w_dec[i*BCD_W +: BCD_W] = cnt_q[i*BCD_W +: BCD_W] - 4'd1;
               borrow = 1'b0;
            end
         end
      end
   end

   always_comb begin
      cnt_d     = cnt_q;
      dir_d     = w_dir_eff;
      turn_d    = 1'b0;
      pre_d     = pre_q;
      running_d = running_q ^ w_run_press;

      if (running_q) begin
         pre_d = w_tick ? '0 : pre_q + 1'b1;
      end

      if (clr) begin
         cnt_d = c_MIN_BCD;
         dir_d = 1'b1;
         pre_d = '0;
      end else if (w_tick) begin
         if (MIN_COUNT == MAX_COUNT) begin
            dir_d  = ~w_dir_eff;
            turn_d = 1'b1;
         end else if (w_dir_eff) begin
            if (cnt_q == c_MAX_BCD) begin
               cnt_d  = c_MAX_M1_BCD;
               dir_d  = 1'b0;
               turn_d = 1'b1;
            end else begin
               cnt_d = w_inc;
            end
         end else begin
            if (cnt_q == c_MIN_BCD) begin
               cnt_d  = c_MIN_P1_BCD;
               dir_d  = 1'b1;
               turn_d = 1'b1;
            end else begin
               cnt_d = w_dec;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= c_MIN_BCD;
         pre_q     <= '0;
         dir_q     <= 1'b1;
         running_q <= 1'b0;
         turn_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         pre_q     <= pre_d;
         dir_q     <= dir_d;
         running_q <= running_d;
         turn_q    <= turn_d;
      end
   end

   assign bcd     = cnt_q;
   assign dir     = dir_q;
   assign running = running_q;
   assign turn    = turn_q;

`ifdef SEG7_DECODE_EN
   logic [7*DIGITS-1:0] seg_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_q <= {DIGITS{SEG7_BLANK}};
      end else begin
         for (int i = 0; i < DIGITS; i++) begin
            seg_q[i*7 +: 7] <= seg7_encode(cnt_q[i*BCD_W +: BCD_W]);
         end
      end
   end

   assign seg = seg_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bcd_pingpong_ctr.sv
// ============================================================================
// Module   : tb_bcd_pingpong_ctr
// Purpose  : Directed vector bench for bcd_pingpong_ctr (2 digits, 0..12).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_pingpong_ctr;

   logic       clk;
   logic       rst;
   logic       btn_run;
   logic       btn_dir;
   logic       clr;
   logic [7:0] bcd;
   logic       dir;
   logic       running;
   logic       turn;
`ifdef SEG7_DECODE_EN
   logic [13:0] seg;
`endif

   int checks;
   int errors;

   typedef struct {
      logic       run;
      logic       dirb;
      logic       clr;
      int         n;
      logic [7:0] e_bcd;
      logic       e_dir;
      logic       e_run;
      logic       e_turn;
   } vec_t;

   vec_t tbl[14];

   bcd_pingpong_ctr #(
      .DIGITS    (2),
      .MIN_COUNT (0),
      .MAX_COUNT (12),
      .PRESCALE  (4),
      .DB_CYCLES (3)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .btn_run (btn_run),
      .btn_dir (btn_dir),
      .clr     (clr),
      .bcd     (bcd),
      .dir     (dir),
      .running (running),
      .turn    (turn)
`ifdef SEG7_DECODE_EN
      ,
      .seg     (seg)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [7:0] e_bcd,
                        input logic e_dir, input logic e_run, input logic e_turn);
      checks++;
      if ({bcd, dir, running, turn} !== {e_bcd, e_dir, e_run, e_turn}) begin
         errors++;
         $display("FAIL %s: got bcd=%h dir=%b running=%b turn=%b, want bcd=%h dir=%b running=%b turn=%b",
                  name, bcd, dir, running, turn, e_bcd, e_dir, e_run, e_turn);
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst     = 1'b1;
      btn_run = 1'b0;
      btn_dir = 1'b0;
      clr     = 1'b0;

      // Edge counts are relative to reset release; ticks land every 4 edges from edge 10
      tbl[0]  = '{1'b1, 1'b0, 1'b0,  5, 8'h00, 1'b1, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 1'b0,  1, 8'h00, 1'b1, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0,  3, 8'h00, 1'b1, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 1'b0,  1, 8'h01, 1'b1, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 1'b0,  4, 8'h02, 1'b1, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 28, 8'h09, 1'b1, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 1'b0,  4, 8'h10, 1'b1, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 1'b0,  8, 8'h12, 1'b1, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 1'b0,  4, 8'h11, 1'b0, 1'b1, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 1'b0,  1, 8'h11, 1'b0, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 1'b0,  7, 8'h09, 1'b0, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 36, 8'h00, 1'b0, 1'b1, 1'b0};
      tbl[12] = '{1'b0, 1'b0, 1'b0,  4, 8'h01, 1'b1, 1'b1, 1'b1};
      tbl[13] = '{1'b0, 1'b0, 1'b0,  1, 8'h01, 1'b1, 1'b1, 1'b0};

      wait_edges(2);
      check("reset", 8'h00, 1'b1, 1'b0, 1'b0);
      rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         btn_run = tbl[i].run;
         btn_dir = tbl[i].dirb;
         clr     = tbl[i].clr;
         wait_edges(tbl[i].n);
         check($sformatf("vec%0d", i), tbl[i].e_bcd, tbl[i].e_dir, tbl[i].e_run, tbl[i].e_turn);
      end

      // Dir press landing on the tick that would step 05 -> 06
      wait_edges(13);
      btn_dir = 1'b1;
      wait_edges(3);
      btn_dir = 1'b0;
      wait_edges(2);
      check("pre_coinc", 8'h05, 1'b1, 1'b1, 1'b0);
      wait_edges(1);
      check("coinc_step", 8'h04, 1'b0, 1'b1, 1'b0);
      wait_edges(1);
      check("coinc_noturn", 8'h04, 1'b0, 1'b1, 1'b0);

      // Bouncing dir button: 1-0-1 one cycle each
      btn_dir = 1'b1;
      wait_edges(1);
      btn_dir = 1'b0;
      wait_edges(1);
      btn_dir = 1'b1;
      wait_edges(1);
      btn_dir = 1'b0;
      wait_edges(10);
      check("bounce_ignored", 8'h01, 1'b0, 1'b1, 1'b0);

      // Clean 3-cycle press; bottom bounce happens one edge before it takes effect
      wait_edges(1);
      btn_dir = 1'b1;
      wait_edges(3);
      btn_dir = 1'b0;
      wait_edges(2);
      check("bottom_bounce", 8'h01, 1'b1, 1'b1, 1'b1);
      wait_edges(1);
      check("dir_press", 8'h01, 1'b0, 1'b1, 1'b0);
      wait_edges(3);
      check("after_press", 8'h00, 1'b0, 1'b1, 1'b0);
      wait_edges(4);
      check("bounce_again", 8'h01, 1'b1, 1'b1, 1'b1);
      wait_edges(44);
      check("top_again", 8'h12, 1'b1, 1'b1, 1'b0);
      wait_edges(20);
      check("seven_down", 8'h07, 1'b0, 1'b1, 1'b0);

      // Clear in the middle of a prescale period
      wait_edges(1);
      clr = 1'b1;
      wait_edges(2);
      check("clr", 8'h00, 1'b1, 1'b1, 1'b0);
      clr = 1'b0;
      wait_edges(3);
      check("clr_prescale", 8'h00, 1'b1, 1'b1, 1'b0);
      wait_edges(1);
      check("after_clr", 8'h01, 1'b1, 1'b1, 1'b0);

      // Asynchronous reset mid-prescale
      wait_edges(1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst", 8'h00, 1'b1, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
